// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } state_e;

    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int CNT_W           = 16;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter that sticks at all-ones; synchronous active-low clear.
module sat_counter16
    import pipe_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline control: memory stall, taken-branch flush, load-use interlock, stall timeout.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       exe_num_write,
    input  logic             exe_reg_write,
    input  logic             exe_mem_read,
    input  logic             branch_taken_exe,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_exe_en,
    output logic             exe_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // Wait counter widens only when the timeout no longer fits in five bits.
    localparam int WAIT_W = (MEM_TIMEOUT > 32) ? 8 : 5;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_stall;
    logic                load_use;
    logic                flush_evt;
    logic                stall_inc;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = exe_mem_read & exe_reg_write & (exe_num_write != 5'd0) &
                       ((id_uses_rs & (id_rs == exe_num_write)) |
                        (id_uses_rt & (id_rt == exe_num_write)));

    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_exe_en     = 1'b0;
        exe_mem_en    = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_flush  = 1'b0;
        mem_wb_bubble = 1'b0;
        mem_timeout   = 1'b0;
        flush_evt     = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;

        if (reset) begin
            case (state_q)
                ERROR: begin
                    mem_timeout = 1'b1;
                end
                default: begin
                    if (mem_stall) begin
                        // Freeze everything upstream of MEM; WB receives bubbles.
                        mem_wb_en     = 1'b1;
                        mem_wb_bubble = 1'b1;
                        if (state_q == RUN) begin
                            state_d    = MEM_WAIT;
                            wait_cnt_d = WAIT_W'(1);
                        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                            state_d = ERROR;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end else begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                        pc_en      = 1'b1;
                        if_id_en   = 1'b1;
                        id_exe_en  = 1'b1;
                        exe_mem_en = 1'b1;
                        mem_wb_en  = 1'b1;
                        if (branch_taken_exe) begin
                            if_id_flush  = 1'b1;
                            id_exe_flush = 1'b1;
                            flush_evt    = 1'b1;
                        end else if (load_use) begin
                            pc_en        = 1'b0;
                            if_id_en     = 1'b0;
                            id_exe_flush = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign stall_inc = reset & (state_q != ERROR) & ~pc_en;

    sat_counter16 u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter16 u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush_evt),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver queues hand-computed expectations, monitor checks them.
module tb_pipeline_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, exe_num_write;
    logic        id_uses_rs, id_uses_rt, exe_reg_write, exe_mem_read;
    logic        branch_taken_exe, mem_req, mem_ready;
    logic        pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
    logic        if_id_flush, id_exe_flush, mem_wb_bubble, mem_timeout;
    logic [15:0] stall_cycles, flush_count;

    pipeline_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clock            (clock),
        .reset            (reset),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .exe_num_write    (exe_num_write),
        .exe_reg_write    (exe_reg_write),
        .exe_mem_read     (exe_mem_read),
        .branch_taken_exe (branch_taken_exe),
        .mem_req          (mem_req),
        .mem_ready        (mem_ready),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .id_exe_en        (id_exe_en),
        .exe_mem_en       (exe_mem_en),
        .mem_wb_en        (mem_wb_en),
        .if_id_flush      (if_id_flush),
        .id_exe_flush     (id_exe_flush),
        .mem_wb_bubble    (mem_wb_bubble),
        .mem_timeout      (mem_timeout),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
    );

    always #5 clock = ~clock;

    // {pc, if_id, id_exe, exe_mem, mem_wb, if_id_flush, id_exe_flush, bubble, timeout}
    localparam logic [8:0] C_ZERO = 9'b00000_000_0;
    localparam logic [8:0] C_NORM = 9'b11111_000_0;
    localparam logic [8:0] C_LU   = 9'b00111_010_0;
    localparam logic [8:0] C_BR   = 9'b11111_110_0;
    localparam logic [8:0] C_MS   = 9'b00001_001_0;
    localparam logic [8:0] C_ERR  = 9'b00000_000_1;

    typedef struct {
        string       name;
        logic [8:0]  ctrl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [8:0] act;
            e   = sb.pop_front();
            act = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
                   if_id_flush, id_exe_flush, mem_wb_bubble, mem_timeout};
            checks++;
            if (act !== e.ctrl || stall_cycles !== e.sc || flush_count !== e.fc) begin
                failures++;
                $display("FAIL %s: ctrl=%b stall=%0d flush=%0d, expected ctrl=%b stall=%0d flush=%0d",
                         e.name, act, stall_cycles, flush_count, e.ctrl, e.sc, e.fc);
            end
        end
    end

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        exe_num_write = 5'd0; exe_reg_write = 1'b0; exe_mem_read = 1'b0;
        branch_taken_exe = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_lu_rs(input logic [4:0] r);
        exe_mem_read = 1'b1; exe_reg_write = 1'b1; exe_num_write = r;
        id_uses_rs = 1'b1; id_rs = r;
    endtask

    // Queue the expectation for the current cycle, then advance to just after the edge.
    task automatic step(input string nm, input logic [8:0] c, input logic [15:0] s, input logic [15:0] f);
        exp_t e;
        e.name = nm; e.ctrl = c; e.sc = s; e.fc = f;
        sb.push_back(e);
        @(posedge clock); #1;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        tick(); tick();
        mem_req = 1'b1;
        step("reset_outputs", C_ZERO, 16'd0, 16'd0);
        idle();
        reset = 1'b1;

        step("idle", C_NORM, 16'd0, 16'd0);
        set_lu_rs(5'd8);
        step("load_use", C_LU, 16'd0, 16'd0);
        idle();
        step("after_load_use", C_NORM, 16'd1, 16'd0);
        set_lu_rs(5'd0);
        step("zero_guard", C_NORM, 16'd1, 16'd0);
        idle();
        step("after_zero_guard", C_NORM, 16'd1, 16'd0);

        exe_mem_read = 1'b1; exe_reg_write = 1'b1; exe_num_write = 5'd9;
        id_uses_rt = 1'b1; id_rt = 5'd9; branch_taken_exe = 1'b1;
        step("branch_over_load_use", C_BR, 16'd1, 16'd0);
        idle();
        step("after_branch", C_NORM, 16'd1, 16'd1);
        exe_mem_read = 1'b1; exe_reg_write = 1'b1; exe_num_write = 5'd9;
        id_uses_rt = 1'b0; id_rt = 5'd9;
        step("rt_not_used", C_NORM, 16'd1, 16'd1);
        idle();

        mem_req = 1'b1; mem_ready = 1'b0;
        step("mem_stall_1", C_MS, 16'd1, 16'd1);
        step("mem_stall_2", C_MS, 16'd2, 16'd1);
        branch_taken_exe = 1'b1;
        step("mem_stall_3_branch_held", C_MS, 16'd3, 16'd1);
        mem_ready = 1'b1;
        step("stall_release_branch", C_BR, 16'd4, 16'd1);
        idle();
        step("after_release", C_NORM, 16'd4, 16'd2);

        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step($sformatf("timeout_stall_%0d", i + 1), C_MS, 16'(4 + i), 16'd2);
        end
        step("error_entered", C_ERR, 16'd20, 16'd2);
        branch_taken_exe = 1'b1; mem_ready = 1'b1;
        step("error_frozen", C_ERR, 16'd20, 16'd2);
        reset = 1'b0;
        step("reset_in_error", C_ZERO, 16'd20, 16'd2);
        reset = 1'b1;
        idle();
        step("after_error_reset", C_NORM, 16'd0, 16'd0);

        set_lu_rs(5'd3);
        step("sat_first", C_LU, 16'd0, 16'd0);
        for (int i = 1; i < 65540; i++) begin
            if (i == 65534) step("sat_near_top", C_LU, 16'hFFFE, 16'd0);
            else            tick();
        end
        idle();
        step("sat_hold", C_NORM, 16'hFFFF, 16'd0);
        step("sat_hold_2", C_NORM, 16'hFFFF, 16'd0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: pending=%0d, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 16, number of consecutive memory-stall cycles after which the block enters ERROR (legal range 2..255).
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-low reset; 0 sampled at posedge clock resets the block.
REQ-004 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 id_uses_rs, id_uses_rt  input  1 each  ID instruction reads rs / rt.
REQ-006 exe_num_write  input  5  destination register of the instruction in EXE.
REQ-007 exe_reg_write, exe_mem_read  input  1 each  EXE instruction writes a register / is a load.
REQ-008 branch_taken_exe  input  1  branch or jump in EXE resolved taken.
REQ-009 mem_req, mem_ready  input  1 each  instruction in MEM accesses data memory / data memory completes this cycle.
REQ-010 pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en  output  1 each  load enables for the PC and the four pipeline registers.
REQ-011 if_id_flush, id_exe_flush, mem_wb_bubble  output  1 each  load a bubble (all fields zero, reg_write 0) into that register.
REQ-012 mem_timeout  output  1  sticky error flag, high in ERROR.
REQ-013 stall_cycles, flush_count  output  16 each  saturating performance counters.

Function
REQ-014 States: RUN, MEM_WAIT, ERROR; 5-bit wait_cnt register.
REQ-015 Controls are combinational from state and inputs (zero-cycle latency); mem_stall = mem_req AND NOT mem_ready.
REQ-016 load_use = exe_mem_read AND exe_reg_write AND exe_num_write != 0 AND ((id_uses_rs AND id_rs == exe_num_write) OR (id_uses_rt AND id_rt == exe_num_write)).
REQ-017 Priority in RUN/MEM_WAIT: mem_stall > branch_taken_exe > load_use > normal.
REQ-018 Normal: all five enables 1; flushes and bubble 0.
REQ-019 mem_stall: pc_en, if_id_en, id_exe_en, exe_mem_en = 0; mem_wb_en = 1, mem_wb_bubble = 1; if_id_flush = id_exe_flush = 0; a taken branch or load-use is held and serviced when the stall releases.
REQ-020 Branch (no mem_stall): all enables 1, if_id_flush = 1, id_exe_flush = 1; a simultaneous load_use is ignored.
REQ-021 Load-use (no mem_stall, no branch): pc_en = 0, if_id_en = 0, id_exe_flush = 1, other enables 1; lasts exactly while the condition holds (one cycle for a single load).
REQ-022 RUN -> MEM_WAIT when mem_stall, wait_cnt <= 1; otherwise stay RUN.
REQ-023 MEM_WAIT: if NOT mem_stall -> RUN (controls per REQ-017, the MEM instruction advances this cycle); else if wait_cnt == MEM_TIMEOUT-1 -> ERROR; else wait_cnt <= wait_cnt+1.
REQ-024 ERROR (MEM_TIMEOUT stalled cycles total): all enables 0, flushes and bubble 0, mem_timeout = 1, counters frozen; exit only by reset.
REQ-025 stall_cycles increments each cycle pc_en == 0 outside ERROR and reset; flush_count increments each cycle REQ-020 applies; both saturate at 16'hFFFF.

Reset
REQ-026 While reset = 0 at posedge: state <= RUN, wait_cnt <= 0, stall_cycles <= 0, flush_count <= 0.
REQ-027 While reset input is 0: all enables, flushes, bubble and mem_timeout are 0 combinationally; reset mid-MEM_WAIT or in ERROR returns to RUN on the next edge.

Structure
REQ-028 State encoding (RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10) and the MEM_TIMEOUT default belong in shared package pipe_ctrl_pkg.
REQ-029 The two counters are instances of one sub-module sat_counter16 (clock, reset, inc, count).

Verification
REQ-030 Load-use: exe_mem_read=1, exe_reg_write=1, exe_num_write=5'd8, id_uses_rs=1, id_rs=5'd8 for one cycle -> pc_en=0, if_id_en=0, id_exe_flush=1 that cycle only, stall_cycles=1 afterwards.
REQ-031 $zero guard: same as REQ-030 with exe_num_write=id_rs=5'd0 -> all enables 1, no flush, stall_cycles unchanged.
REQ-032 Branch plus load-use in same cycle -> if_id_flush=1, id_exe_flush=1, pc_en=1, flush_count +1, stall_cycles unchanged.
REQ-033 mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 -> 3 frozen cycles with mem_wb_bubble=1, all enables 1 on the 4th, state RUN, stall_cycles=3.
REQ-034 mem_req=1, mem_ready=0 held, MEM_TIMEOUT=16 -> ERROR after 16 stalled cycles, mem_timeout=1, stall_cycles=16 and frozen; reset=0 for one edge -> RUN, mem_timeout=0, counters 0.
REQ-035 Saturation: force 65540 load-use cycles -> stall_cycles holds 16'hFFFF.
